mem_port_arbiter: RTL

Two-requester arbiter and sequencer that shares one single-port synchronous instruction/data memory between the RV32I core's fetch unit and load/store unit. It sits between the core and the unified memory inside `RISC_V_PROCESSOR`. Each cycle it grants at most one access, registers it onto the memory port, and routes returning read data back to the owner. Load/store has priority, bounded by a starvation guard for fetch.

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch / load-store requesters, the arbiter and the shared memory port.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   // Fetch requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   // Load/store requester
   logic              ls_req;
   logic              ls_we;
   logic [BE_W-1:0]   ls_be;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;

   // Single-port synchronous memory
   logic              mem_en;
   logic              mem_we;
   logic [BE_W-1:0]   mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
      output ls_gnt, ls_rvalid, ls_rdata,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
      input  ls_gnt, ls_rvalid, ls_rdata,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch and load/store: priority to load/store,
// bounded by a burst counter so fetch is served after MAX_BURST consecutive load/store grants.
module mem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam int         BE_W        = DATA_W / 8;
   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

   // Owner of an access travelling alongside the memory pipeline
   typedef struct packed {
      logic rd;   // a read whose data must be returned
      logic ls;   // owner is load/store (else fetch)
   } tag_t;

   typedef struct packed {
      logic              en;
      logic              we;
      logic [BE_W-1:0]   be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } issue_t;

   logic       grant_ls;
   logic       grant_if;
   logic [3:0] burst_q, burst_d;
   issue_t     issue_q, issue_d;
   tag_t       tag1_q, tag1_d;
   tag_t       tag2_q;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      grant_ls = 1'b0;
      grant_if = 1'b0;
      if (reset) begin
         if (bus.ls_req && (!bus.if_req || (burst_q < BURST_LIMIT))) begin
            grant_ls = 1'b1;
         end else if (bus.if_req) begin
            grant_if = 1'b1;
         end
      end
   end

   // Counts load/store grants that fetch has had to wait behind
   always_comb begin
      burst_d = burst_q;
      if (!bus.if_req || grant_if) begin
         burst_d = '0;
      end else if (grant_ls) begin
         burst_d = burst_q + 4'd1;
      end
   end

   // Idle cycles keep address, data and byte enables; only en/we drop
   always_comb begin
      issue_d    = issue_q;
      issue_d.en = 1'b0;
      issue_d.we = 1'b0;
      tag1_d     = '0;
      if (grant_ls) begin
         issue_d.en    = 1'b1;
         issue_d.we    = bus.ls_we;
         issue_d.be    = bus.ls_be;
         issue_d.addr  = bus.ls_addr;
         issue_d.wdata = bus.ls_wdata;
         tag1_d.rd     = !bus.ls_we;
         tag1_d.ls     = 1'b1;
      end else if (grant_if) begin
         issue_d.en   = 1'b1;
         issue_d.we   = 1'b0;
         issue_d.be   = '1;
         issue_d.addr = bus.if_addr;
         tag1_d.rd    = 1'b1;
         tag1_d.ls    = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         burst_q <= '0;
         issue_q <= '0;
         tag1_q  <= '0;
         tag2_q  <= '0;
      end else begin
         burst_q <= burst_d;
         issue_q <= issue_d;
         tag1_q  <= tag1_d;
         tag2_q  <= tag1_q;
      end
   end

   assign bus.if_gnt    = grant_if;
   assign bus.ls_gnt    = grant_ls;

   assign bus.mem_en    = issue_q.en;
   assign bus.mem_we    = issue_q.we;
   assign bus.mem_be    = issue_q.be;
   assign bus.mem_addr  = issue_q.addr;
   assign bus.mem_wdata = issue_q.wdata;

   // Read data is shared; the tag two stages back says whose it is
   assign bus.if_rvalid = tag2_q.rd && !tag2_q.ls;
   assign bus.ls_rvalid = tag2_q.rd && tag2_q.ls;
   assign bus.if_rdata  = bus.mem_rdata;
   assign bus.ls_rdata  = bus.mem_rdata;
endmodule
